// File: rtl/xd_pulse_pacer.sv
// Source-domain pacer ahead of a toggle pulse synchronizer: counts incoming event
// requests and re-emits them as single-cycle pulses spaced at least MIN_GAP cycles apart.
module xd_pulse_pacer #(
  parameter int unsigned MIN_GAP = 8,
  parameter int unsigned PEND_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              clr_ovf,
  output logic              flag_src,
  output logic [PEND_W-1:0] pending,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned        GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0]   GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [PEND_W-1:0]  PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0]  PMAX     = {PEND_W{1'b1}};

  logic [GAP_W-1:0]  gap_cnt_r;
  logic [GAP_W-1:0]  gap_nxt_s;
  logic [PEND_W-1:0] pend_r;
  logic [PEND_W-1:0] pend_nxt_s;
  logic              flag_r;
  logic              ovf_r;
  logic              can_emit_s;
  logic              lose_s;
  logic              ovf_nxt_s;

  // Emit decision, spacing timer, backlog and sticky-overflow next state.
  always_comb begin
    can_emit_s = (gap_cnt_r == GAP_ZERO) && ((pend_r != PEND_ZERO) || req);
    lose_s     = 1'b0;
    pend_nxt_s = pend_r;

    if (can_emit_s) begin
      gap_nxt_s = GAP_LOAD;
    end else if (gap_cnt_r != GAP_ZERO) begin
      gap_nxt_s = gap_cnt_r - GAP_W'(1);
    end else begin
      gap_nxt_s = gap_cnt_r;
    end

    // A req on an emit cycle either is the emitted event or replaces it in the queue.
    case ({req, can_emit_s})
      2'b11: pend_nxt_s = pend_r;
      2'b10: begin
        if (pend_r != PMAX) begin
          pend_nxt_s = pend_r + PEND_W'(1);
        end else begin
          pend_nxt_s = pend_r;
          lose_s     = 1'b1;
        end
      end
      2'b01:   pend_nxt_s = pend_r - PEND_W'(1);
      default: pend_nxt_s = pend_r;
    endcase

    if (lose_s) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_cnt_r <= GAP_ZERO;
      pend_r    <= PEND_ZERO;
      flag_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      gap_cnt_r <= gap_nxt_s;
      pend_r    <= pend_nxt_s;
      flag_r    <= can_emit_s;
      ovf_r     <= ovf_nxt_s;
    end
  end

  assign flag_src = flag_r;
  assign pending  = pend_r;
  assign overflow = ovf_r;
  assign busy     = (pend_r != PEND_ZERO) || (gap_cnt_r != GAP_ZERO);

endmodule

// File: tb/tb_xd_pulse_pacer.sv
// Randomized bench for xd_pulse_pacer against a timestamp/count model, plus directed
// literal expectations that pin the model on the documented scenarios.
module tb_xd_pulse_pacer;

  localparam int MIN_GAP = 8;
  localparam int PEND_W  = 4;
  localparam int PMAX    = (1 << PEND_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic              clr_ovf;
  logic              flag_src;
  logic [PEND_W-1:0] pending;
  logic              busy;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state: last emit decision edge index replaces any timer
  int edge_idx   = 0;
  int last_dec   = -1000;
  int m_pending  = 0;
  bit m_flag     = 1'b0;
  bit m_ovf      = 1'b0;
  bit m_busy     = 1'b0;
  bit m_rst_edge = 1'b0;
  int m_accepted = 0;
  int m_lost     = 0;
  int dut_pulses = 0;

  xd_pulse_pacer #(.MIN_GAP(MIN_GAP), .PEND_W(PEND_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .clr_ovf  (clr_ovf),
    .flag_src (flag_src),
    .pending  (pending),
    .busy     (busy),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: an event may go out when MIN_GAP edges have passed since the last one.
  always @(posedge clk) begin
    bit can;
    bit lose;
    lose = 1'b0;
    if (!rst_n) begin
      m_pending  = 0;
      m_flag     = 1'b0;
      m_ovf      = 1'b0;
      last_dec   = edge_idx - 1000;
      m_accepted = 0;
      m_lost     = 0;
      m_rst_edge = 1'b1;
    end else begin
      m_rst_edge = 1'b0;
      can = ((edge_idx - last_dec) >= MIN_GAP) && (m_pending > 0 || req);
      if (req) m_accepted++;
      if (can) begin
        last_dec = edge_idx;
        if (!req) m_pending--;
      end else if (req) begin
        if (m_pending < PMAX) m_pending++;
        else begin
          lose = 1'b1;
          m_lost++;
        end
      end
      if (lose) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_flag = can;
    end
    m_busy = (m_pending != 0) || ((edge_idx - last_dec) < MIN_GAP - 1);
    edge_idx++;
  end

  task automatic report(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every output against the model, plus event conservation.
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_rst_edge) dut_pulses = 0;
      else if (flag_src === 1'b1) dut_pulses++;
      report("flag_src", {31'd0, flag_src}, {31'd0, m_flag});
      report("pending", {{(32-PEND_W){1'b0}}, pending}, m_pending);
      report("busy", {31'd0, busy}, {31'd0, m_busy});
      report("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      report("conservation", dut_pulses + int'(pending) + m_lost, m_accepted);
    end
  end

  task automatic drive(input logic r, input logic c, input logic rn);
    req     = r;
    clr_ovf = c;
    rst_n   = rn;
    @(negedge clk);
  endtask

  int pulses;
  int dens;

  initial begin
    req = 1'b0; clr_ovf = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    report("rst_flag", {31'd0, flag_src}, 32'd0);
    report("rst_pending", {28'd0, pending}, 32'd0);
    report("rst_busy", {31'd0, busy}, 32'd0);
    report("rst_ovf", {31'd0, overflow}, 32'd0);

    // single req from idle
    drive(1'b1, 1'b0, 1'b1);
    report("t1_flag_c1", {31'd0, flag_src}, 32'd1);
    report("t1_pend_c1", {28'd0, pending}, 32'd0);
    report("t1_busy_c1", {31'd0, busy}, 32'd1);
    for (int i = 2; i <= 8; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      report("t1_flag", {31'd0, flag_src}, 32'd0);
      report("t1_busy", {31'd0, busy}, (i <= 7) ? 32'd1 : 32'd0);
    end

    // three back-to-back reqs
    drive(1'b1, 1'b0, 1'b1);
    report("t2_flag_c1", {31'd0, flag_src}, 32'd1);
    drive(1'b1, 1'b0, 1'b1);
    report("t2_pend_c2", {28'd0, pending}, 32'd1);
    drive(1'b1, 1'b0, 1'b1);
    report("t2_pend_c3", {28'd0, pending}, 32'd2);
    for (int t = 4; t <= 30; t++) begin
      drive(1'b0, 1'b0, 1'b1);
      report("t2_flag", {31'd0, flag_src}, (t == 9 || t == 17) ? 32'd1 : 32'd0);
      if (t == 9)  report("t2_pend_c9", {28'd0, pending}, 32'd1);
      if (t == 17) report("t2_pend_c17", {28'd0, pending}, 32'd0);
      if (t == 23) report("t2_busy_c23", {31'd0, busy}, 32'd1);
      if (t == 24) report("t2_busy_c24", {31'd0, busy}, 32'd0);
    end

    // req held 20 cycles: emits at 0,8,16, saturates at 15, loses 2
    pulses = 0;
    for (int t = 1; t <= 20; t++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (flag_src) pulses++;
      if (t == 9) begin
        report("t3_req_on_emit_pend", {28'd0, pending}, 32'd7);
        report("t3_req_on_emit_flag", {31'd0, flag_src}, 32'd1);
      end
      if (t == 18) begin
        report("t3_pend_full", {28'd0, pending}, PMAX);
        report("t3_ovf_c18", {31'd0, overflow}, 32'd0);
      end
      if (t == 19) report("t3_ovf_c19", {31'd0, overflow}, 32'd1);
    end
    report("t3_fill_pulses", pulses, 32'd3);
    pulses = 0;
    for (int t = 0; t < 130; t++) begin
      drive(1'b0, 1'b0, 1'b1);
      if (flag_src) pulses++;
    end
    report("t3_drain_pulses", pulses, 32'd15);
    report("t3_pend_end", {28'd0, pending}, 32'd0);
    report("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

    // plain clear, then clear coincident with a loss
    drive(1'b0, 1'b1, 1'b1);
    report("t4_clr", {31'd0, overflow}, 32'd0);
    for (int t = 1; t <= 19; t++) drive(1'b1, 1'b0, 1'b1);
    report("t4_ovf_set", {31'd0, overflow}, 32'd1);
    drive(1'b1, 1'b1, 1'b1);
    report("t4_clr_vs_loss", {31'd0, overflow}, 32'd1);
    drive(1'b0, 1'b1, 1'b1);
    report("t4_clr_after", {31'd0, overflow}, 32'd0);

    // mid-burst reset discards the backlog
    for (int t = 0; t < 35; t++) drive(1'b0, 1'b0, 1'b1);
    report("t5_pend_before", {28'd0, pending}, 32'd11);
    drive(1'b0, 1'b0, 1'b0);
    report("t5_flag", {31'd0, flag_src}, 32'd0);
    report("t5_pend", {28'd0, pending}, 32'd0);
    report("t5_busy", {31'd0, busy}, 32'd0);
    for (int t = 0; t < 10; t++) begin
      drive(1'b0, 1'b0, 1'b1);
      report("t5_quiet", {31'd0, flag_src}, 32'd0);
    end
    drive(1'b1, 1'b0, 1'b1);
    report("t5_fresh_req", {31'd0, flag_src}, 32'd1);

    // randomized traffic with varying density, rare clears and resets
    dens = 20;
    for (int t = 0; t < 4000; t++) begin
      if (t % 200 == 0) dens = $urandom_range(2, 95);
      drive(($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0,
            ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
